// File: rtl/scan_mux.sv
// Registered 2**M-to-1 channel mux with MANUAL select and SCAN auto-stepping over enabled channels.
// Optional macro SCAN_MUX_PARITY_EN adds a registered out_parity output.
module scan_mux #(
    parameter int M     = 3,
    parameter int W     = 8,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [M-1:0]         select,
    input  logic [(2**M)*W-1:0]  in,
    input  logic [2**M-1:0]      enable_mask,
    input  logic                 hold,
    output logic [W-1:0]         out,
    output logic [M-1:0]         out_sel,
    output logic                 out_valid,
`ifdef SCAN_MUX_PARITY_EN
    output logic                 out_parity,
`endif
    output logic                 wrap
);

    localparam int N  = 2**M;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {MANUAL, SCAN} state_t;

    state_t          state, state_nxt;
    logic [M-1:0]    ptr, ptr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [M-1:0]    chan;
    logic            chan_vld;
    logic            wrap_nxt;
    logic [W-1:0]    chan_data;

    // first enabled index at base+first, base+first+1, ... modulo N; returns base if none found
    function automatic logic [M-1:0] find_enabled(input logic [N-1:0] mask,
                                                  input logic [M-1:0] base,
                                                  input int first);
        logic [M-1:0] res;
        logic [M-1:0] idx;
        logic         found;
        res   = base;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = base + M'(k + first);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_nxt = mode ? SCAN : MANUAL;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        chan      = select;
        chan_vld  = enable_mask[select];
        wrap_nxt  = 1'b0;
        if (mode && state == MANUAL) begin
            ptr_nxt  = find_enabled(enable_mask, select, 0);
            cnt_nxt  = '0;
            chan     = ptr_nxt;
            chan_vld = enable_mask[ptr_nxt];
        end else if (mode) begin
            chan     = ptr;
            chan_vld = enable_mask[ptr];
            if (enable_mask == '0) begin
                chan_vld = 1'b0;
            end else if (!enable_mask[ptr] || (!hold && cnt == CW'(DWELL - 1))) begin
                // a disabled current channel forces the advance even under hold
                ptr_nxt  = find_enabled(enable_mask, ptr, 1);
                cnt_nxt  = '0;
                chan     = ptr_nxt;
                chan_vld = 1'b1;
                wrap_nxt = (ptr_nxt <= ptr);
            end else if (!hold) begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    assign chan_data = in[32'(chan) * W +: W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MANUAL;
            ptr        <= '0;
            cnt        <= '0;
            out        <= '0;
            out_sel    <= '0;
            out_valid  <= 1'b0;
            wrap       <= 1'b0;
`ifdef SCAN_MUX_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            cnt        <= cnt_nxt;
            out        <= chan_vld ? chan_data : '0;
            out_sel    <= chan;
            out_valid  <= chan_vld;
            wrap       <= wrap_nxt;
`ifdef SCAN_MUX_PARITY_EN
            out_parity <= chan_vld ? ^chan_data : 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: driver predicts with an enabled-channel-list model, monitor compares each cycle.
module tb_scan_mux;

    localparam int M = 3;
    localparam int W = 8;
    localparam int DWELL = 4;
    localparam int N = 2**M;

    logic             clk = 1'b0;
    logic             reset;
    logic             mode;
    logic [M-1:0]     select;
    logic [N*W-1:0]   in;
    logic [N-1:0]     enable_mask;
    logic             hold;
    logic [W-1:0]     out;
    logic [M-1:0]     out_sel;
    logic             out_valid;
    logic             wrap;

    scan_mux #(.M(M), .W(W), .DWELL(DWELL)) dut (
        .clk(clk), .reset(reset), .mode(mode), .select(select), .in(in),
        .enable_mask(enable_mask), .hold(hold),
        .out(out), .out_sel(out_sel), .out_valid(out_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] out;
        logic [M-1:0] sel;
        logic         vld;
        logic         wrap;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // reference model state: whether scanning, channel on show, cycles it has been shown
    bit   m_scan = 0;
    int   m_ptr = 0;
    int   m_shown = 0;

    function automatic int chan_in(int c);
        logic [N*W-1:0] v;
        v = in;
        return int'(v[c*W +: W]);
    endfunction

    // pick from the list of enabled channels: first one >= base (incl) or > base, else lowest
    function automatic int pick(int base, bit incl);
        int lst[$];
        for (int i = 0; i < N; i++) if (enable_mask[i]) lst.push_back(i);
        if (lst.size() == 0) return base;
        foreach (lst[j]) if (lst[j] > base || (incl && lst[j] == base)) return lst[j];
        return lst[0];
    endfunction

    task automatic predict_push();
        exp_t e;
        int   np;
        e = '0;
        if (reset) begin
            m_scan = 0; m_ptr = 0; m_shown = 0;
        end else if (!mode) begin
            m_scan = 0;
            e.sel = M'(select);
            e.vld = enable_mask[select];
            e.out = e.vld ? W'(chan_in(int'(select))) : '0;
        end else begin
            if (!m_scan) begin
                m_scan = 1;
                m_ptr = pick(int'(select), 1'b1);
                m_shown = 1;
            end else if (enable_mask != 0) begin
                if (!enable_mask[m_ptr] || (!hold && m_shown == DWELL)) begin
                    np = pick(m_ptr, 1'b0);
                    e.wrap = (np <= m_ptr);
                    m_ptr = np;
                    m_shown = 1;
                end else if (!hold) begin
                    m_shown++;
                end
            end
            e.sel = M'(m_ptr);
            e.vld = enable_mask[m_ptr];
            e.out = e.vld ? W'(chan_in(m_ptr)) : '0;
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(int n);
        for (int k = 0; k < n; k++) begin
            predict_push();
            @(negedge clk);
        end
    endtask

    task automatic set_default_in();
        for (int i = 0; i < N; i++) in[i*W +: W] = W'(8'h10 + i);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (out !== e.out || out_sel !== e.sel || out_valid !== e.vld || wrap !== e.wrap) begin
                    fails++;
                    $display("FAIL cycle%0d: got out=%h sel=%0d vld=%b wrap=%b, expected out=%h sel=%0d vld=%b wrap=%b",
                             cyc, out, out_sel, out_valid, wrap, e.out, e.sel, e.vld, e.wrap);
                end
            end
        end
    end

    initial begin : driver
        reset = 1; mode = 0; select = '0; enable_mask = '1; hold = 0;
        set_default_in();
        @(negedge clk);
        tick(2);
        reset = 0;
        // manual select with channel 5 enabled then masked
        select = 3'd5; in[5*W +: W] = 8'hA5;
        tick(2);
        enable_mask[5] = 1'b0;
        tick(2);
        // full scan from channel 0
        set_default_in(); enable_mask = '1; select = 3'd0; mode = 1;
        tick(40);
        // sparse mask 0,2,7
        mode = 0; tick(1);
        enable_mask = 8'b1000_0101; mode = 1;
        tick(30);
        // hold after two dwell cycles on ch3
        mode = 0; enable_mask = '1; select = 3'd3; tick(1);
        mode = 1; tick(2);
        hold = 1; tick(10);
        hold = 0; tick(6);
        // mask-disable of current channel, then empty mask
        mode = 0; select = 3'd2; tick(1);
        mode = 1; tick(2);
        enable_mask[2] = 1'b0; tick(3);
        enable_mask = '0; tick(3);
        enable_mask = 8'h41; tick(3);
        // reset mid-scan on ch6
        mode = 0; enable_mask = '1; select = 3'd6; tick(1);
        mode = 1; tick(2);
        reset = 1; tick(1);
        reset = 0; mode = 0; tick(3);
        // randomized phase
        for (int r = 0; r < 1500; r++) begin
            for (int i = 0; i < N; i++) in[i*W +: W] = W'($urandom);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) select = M'($urandom);
            if ($urandom_range(0, 14) == 0)
                enable_mask = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            hold = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        reset = 0;
        tick(1);
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
